i2s_frame_sched: RTL

Frame scheduler and serializer controller for the stereo I2S output path. It accepts left/right sample pairs from an upstream source through a valid/ready handshake and buffers one pair. It generates SCLK and LRCLK from the system clock and shifts each sample MSB-first onto SDIN in standard I2S framing. It sits between the audio sample producer and the CS4344 DAC pins; MCLK is driven elsewhere.

---
 rtl/i2s_frame_sched.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2s_frame_sched.sv
// Stereo I2S frame scheduler: one-pair input buffer, SCLK/LRCLK generation, MSB-first SDIN.
// Optional macro I2S_SCHED_HOLD_EN: on underrun replay the last loaded pair instead of muting.
module i2s_frame_sched #(
    parameter int WIDTH = 16,
    parameter int SLOT  = 32,
    parameter int DIV   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] in_left,
    input  logic [WIDTH-1:0] in_right,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sclk,
    output logic             lrclk,
    output logic             sdin,
    output logic             frame_start,
    output logic             underrun,
    output logic             busy
);

    localparam int FRAME = 2 * SLOT;
    localparam int BW    = $clog2(FRAME);
    localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    // Word select is high over the right slot, shifted one SCLK earlier than the data.
    function automatic logic lr_of(input logic [BW-1:0] bc);
        int b;
        b = int'(bc);
        return (b >= SLOT - 1) && (b <= FRAME - 2);
    endfunction

    function automatic logic data_of(input logic [BW-1:0] bc,
                                     input logic [WIDTH-1:0] l,
                                     input logic [WIDTH-1:0] r);
        int         b;
        logic [IW-1:0] idx;
        logic       bit_v;
        b     = int'(bc);
        idx   = '0;
        bit_v = 1'b0;
        if (b < WIDTH) begin
            idx   = IW'(WIDTH - 1 - b);
            bit_v = l[idx];
        end else if ((b >= SLOT) && (b < SLOT + WIDTH)) begin
            idx   = IW'(WIDTH - 1 - (b - SLOT));
            bit_v = r[idx];
        end else begin
            bit_v = 1'b0;
        end
        return bit_v;
    endfunction

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             sclk_q, sclk_d, lrclk_q, lrclk_d, sdin_q, sdin_d;
    logic             fs_q, fs_d, ur_q, ur_d, busy_q, busy_d;
    logic             pend_full_q, pend_full_d;
    logic [WIDTH-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic [WIDTH-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
    logic [WIDTH-1:0] last_l_q, last_l_d, last_r_q, last_r_d;

    logic             tick_s, fall_s, wrap_s, stop_s, load_s, accept_s;
    logic [BW-1:0]    bit_nxt_s;
    logic [WIDTH-1:0] fill_l_s, fill_r_s, load_l_s, load_r_s;

`ifdef I2S_SCHED_HOLD_EN
    assign fill_l_s = last_l_q;
    assign fill_r_s = last_r_q;
`else
    assign fill_l_s = '0;
    assign fill_r_s = '0;
`endif

    assign tick_s    = (state_q != ST_IDLE) && (div_q == DIV_LAST);
    assign fall_s    = tick_s && sclk_q;
    assign wrap_s    = (bit_q == BIT_LAST);
    // A stopping frame ends on the wrap fall instead of loading the next pair.
    assign stop_s    = fall_s && wrap_s && (state_q == ST_STOPPING) && !enable;
    assign load_s    = fall_s && wrap_s && !stop_s;
    assign bit_nxt_s = wrap_s ? '0 : (bit_q + BW'(1));
    assign load_l_s  = pend_full_q ? pend_l_q : fill_l_s;
    assign load_r_s  = pend_full_q ? pend_r_q : fill_r_s;
    assign in_ready  = !pend_full_q || load_s;
    assign accept_s  = in_valid && in_ready;

    assign sclk        = sclk_q;
    assign lrclk       = lrclk_q;
    assign sdin        = sdin_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;
    assign busy        = busy_q;

    // Next-state: FSM, SCLK divider, bit position, shifters and pending buffer.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        sclk_d      = sclk_q;
        lrclk_d     = lrclk_q;
        sdin_d      = sdin_q;
        fs_d        = 1'b0;
        ur_d        = 1'b0;
        sh_l_d      = sh_l_q;
        sh_r_d      = sh_r_q;
        pend_full_d = pend_full_q;
        pend_l_d    = pend_l_q;
        pend_r_d    = pend_r_q;
        last_l_d    = last_l_q;
        last_r_d    = last_r_q;

        case (state_q)
            ST_IDLE: begin
                sclk_d  = 1'b0;
                lrclk_d = 1'b0;
                sdin_d  = 1'b0;
                div_d   = '0;
                bit_d   = BIT_LAST;
                if (enable) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN, ST_STOPPING: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if (stop_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOPPING;
                end
                if (tick_s) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                end else begin
                    div_d  = div_q + DW'(1);
                    sclk_d = sclk_q;
                end
                if (stop_s) begin
                    bit_d   = BIT_LAST;
                    lrclk_d = 1'b0;
                    sdin_d  = 1'b0;
                end else if (fall_s) begin
                    bit_d   = bit_nxt_s;
                    lrclk_d = lr_of(bit_nxt_s);
                    if (load_s) begin
                        sh_l_d = load_l_s;
                        sh_r_d = load_r_s;
                        sdin_d = data_of(bit_nxt_s, load_l_s, load_r_s);
                        fs_d   = 1'b1;
                        ur_d   = !pend_full_q;
                    end else begin
                        sdin_d = data_of(bit_nxt_s, sh_l_q, sh_r_q);
                    end
                end else begin
                    bit_d = bit_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accept wins over drain so a same-cycle refill keeps the buffer full.
        if (accept_s) begin
            pend_full_d = 1'b1;
            pend_l_d    = in_left;
            pend_r_d    = in_right;
        end else if (load_s) begin
            pend_full_d = 1'b0;
        end else begin
            pend_full_d = pend_full_q;
        end

        if (load_s && pend_full_q) begin
            last_l_d = pend_l_q;
            last_r_d = pend_r_q;
        end else begin
            last_l_d = last_l_q;
            last_r_d = last_r_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bit_q       <= BIT_LAST;
            sclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            sdin_q      <= 1'b0;
            fs_q        <= 1'b0;
            ur_q        <= 1'b0;
            busy_q      <= 1'b0;
            pend_full_q <= 1'b0;
            pend_l_q    <= '0;
            pend_r_q    <= '0;
            sh_l_q      <= '0;
            sh_r_q      <= '0;
            last_l_q    <= '0;
            last_r_q    <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            sclk_q      <= sclk_d;
            lrclk_q     <= lrclk_d;
            sdin_q      <= sdin_d;
            fs_q        <= fs_d;
            ur_q        <= ur_d;
            busy_q      <= busy_d;
            pend_full_q <= pend_full_d;
            pend_l_q    <= pend_l_d;
            pend_r_q    <= pend_r_d;
            sh_l_q      <= sh_l_d;
            sh_r_q      <= sh_r_d;
            last_l_q    <= last_l_d;
            last_r_q    <= last_r_d;
        end
    end

endmodule
